// File: rtl/tiamc1_analog_pkg.sv
// Shared constants and FSM state type for the tiamc1 analog input conditioning stage.
package tiamc1_analog_pkg;

  localparam int unsigned DEADZONE_DEFAULT = 8;
  localparam int unsigned MAX_STEP_DEFAULT = 16;
  localparam logic [7:0]  CENTRE_DEFAULT   = 8'h80;

  localparam int unsigned JOY_RIGHT = 0;
  localparam int unsigned JOY_LEFT  = 1;
  localparam int unsigned JOY_DOWN  = 2;
  localparam int unsigned JOY_UP    = 3;

  localparam int unsigned CFG_PADDLE    = 0;
  localparam int unsigned CFG_NO_INVERT = 1;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CONVERT,
    SLEW,
    PUBLISH
  } state_t;

endpackage

// File: rtl/tiamc1_axis_slew.sv
// Per-axis target conversion, invert, optional moving average and slew limiting.
// Optional 4-deep target averaging is enabled by defining TIAMC1_ANALOG_FILTER_EN.
module tiamc1_axis_slew
  import tiamc1_analog_pkg::*;
#(
  parameter int unsigned DEADZONE = DEADZONE_DEFAULT,
  parameter int unsigned MAX_STEP = MAX_STEP_DEFAULT,
  parameter logic [7:0]  CENTRE   = CENTRE_DEFAULT
) (
  input  logic       clk_sys,
  input  logic       reset_sig,
  input  logic       conv_en,
  input  logic       slew_en,
  input  logic       pub_en,
  input  logic [7:0] analog,
  input  logic       dig_pos,
  input  logic       dig_neg,
  input  logic [7:0] paddle_val,
  input  logic       paddle_mode,
  input  logic       no_invert,
  output logic [7:0] pos
);

  localparam logic signed [8:0] STEP_HI = 9'(MAX_STEP);
  localparam logic signed [8:0] STEP_LO = -STEP_HI;

  logic [8:0]        abs_c;
  logic [7:0]        raw_c;
  logic [7:0]        tgt_c;
  logic [7:0]        src_c;
  logic [7:0]        next_c;
  logic [7:0]        next_q;
  logic signed [8:0] diff_c;
  logic signed [8:0] step_c;

  // Magnitude in 9 bits so that -128 reads as 128.
  assign abs_c = analog[7] ? 9'(9'd0 - {analog[7], analog}) : {1'b0, analog};

  always_comb begin
    raw_c = CENTRE;
    if (paddle_mode)
      raw_c = paddle_val;
    else if (abs_c >= 9'(DEADZONE))
      raw_c = analog ^ 8'h80;
    else if (dig_pos && !dig_neg)
      raw_c = 8'hFF;
    else if (dig_neg && !dig_pos)
      raw_c = 8'h00;
    tgt_c = no_invert ? raw_c : 8'hFF - raw_c;
  end

`ifdef TIAMC1_ANALOG_FILTER_EN
  logic [7:0] hist_q [4];
  logic [9:0] sum_c;

  always_ff @(posedge clk_sys) begin
    if (reset_sig) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= CENTRE;
    end else if (conv_en) begin
      hist_q[0] <= tgt_c;
      for (int i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  assign sum_c = 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]) + 10'(hist_q[3]);
  assign src_c = sum_c[9:2];
`else
  logic [7:0] tgt_q;

  always_ff @(posedge clk_sys) begin
    if (reset_sig)
      tgt_q <= CENTRE;
    else if (conv_en)
      tgt_q <= tgt_c;
  end

  assign src_c = tgt_q;
`endif

  // Clamp the signed distance to the target so the axis never overshoots or wraps.
  always_comb begin
    diff_c = $signed({1'b0, src_c}) - $signed({1'b0, pos});
    if (diff_c > STEP_HI)
      step_c = STEP_HI;
    else if (diff_c < STEP_LO)
      step_c = STEP_LO;
    else
      step_c = diff_c;
    next_c = paddle_mode ? src_c : pos + step_c[7:0];
  end

  always_ff @(posedge clk_sys) begin
    if (reset_sig) begin
      next_q <= CENTRE;
      pos    <= CENTRE;
    end else begin
      if (slew_en) next_q <= next_c;
      if (pub_en)  pos    <= next_q;
    end
  end

endmodule

// File: rtl/tiamc1_analog_in.sv
// Frame-rate conditioning of joystick/paddle inputs into two 8-bit axis positions.
// Build option TIAMC1_ANALOG_FILTER_EN adds per-axis target averaging (see tiamc1_axis_slew).
module tiamc1_analog_in
  import tiamc1_analog_pkg::*;
#(
  parameter int unsigned DEADZONE = DEADZONE_DEFAULT,
  parameter int unsigned MAX_STEP = MAX_STEP_DEFAULT,
  parameter logic [7:0]  CENTRE   = CENTRE_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset_sig,
  input  logic        vblank,
  input  logic [31:0] joystick_0,
  input  logic [15:0] joystick_analog_0,
  input  logic [7:0]  paddle_0,
  input  logic [1:0]  cfg_analog,
  output logic [7:0]  pos_x,
  output logic [7:0]  pos_y,
  output logic        pos_valid
);

  state_t      state_q;
  state_t      state_d;
  logic        vblank_q;
  logic        armed_q;
  logic        rise_c;
  logic        cap_en_c;
  logic        conv_en_c;
  logic        slew_en_c;
  logic        pub_en_c;
  logic [3:0]  joy_q;
  logic [15:0] ana_q;
  logic [7:0]  paddle_q;
  logic [1:0]  cfg_q;
  logic        unused_joy;

  assign unused_joy = &{1'b0, joystick_0[31:4]};

  // A level already high when reset releases is not a rise; vblank must drop first.
  always_ff @(posedge clk_sys) begin
    if (reset_sig) begin
      vblank_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      vblank_q <= vblank;
      armed_q  <= armed_q | ~vblank;
    end
  end

  assign rise_c = vblank & ~vblank_q & armed_q;

  always_ff @(posedge clk_sys) begin
    if (reset_sig)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cap_en_c  = 1'b0;
    conv_en_c = 1'b0;
    slew_en_c = 1'b0;
    pub_en_c  = 1'b0;
    case (state_q)
      IDLE:    if (rise_c) state_d = CAPTURE;
      CAPTURE: begin cap_en_c  = 1'b1; state_d = CONVERT; end
      CONVERT: begin conv_en_c = 1'b1; state_d = SLEW;    end
      SLEW:    begin slew_en_c = 1'b1; state_d = PUBLISH; end
      PUBLISH: begin pub_en_c  = 1'b1; state_d = IDLE;    end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset_sig) begin
      joy_q    <= '0;
      ana_q    <= '0;
      paddle_q <= '0;
      cfg_q    <= '0;
    end else if (cap_en_c) begin
      joy_q    <= joystick_0[3:0];
      ana_q    <= joystick_analog_0;
      paddle_q <= paddle_0;
      cfg_q    <= cfg_analog;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset_sig)
      pos_valid <= 1'b0;
    else
      pos_valid <= pub_en_c;
  end

  tiamc1_axis_slew #(.DEADZONE(DEADZONE), .MAX_STEP(MAX_STEP), .CENTRE(CENTRE)) u_axis_x (
    .clk_sys     (clk_sys),
    .reset_sig   (reset_sig),
    .conv_en     (conv_en_c),
    .slew_en     (slew_en_c),
    .pub_en      (pub_en_c),
    .analog      (ana_q[7:0]),
    .dig_pos     (joy_q[JOY_RIGHT]),
    .dig_neg     (joy_q[JOY_LEFT]),
    .paddle_val  (paddle_q),
    .paddle_mode (cfg_q[CFG_PADDLE]),
    .no_invert   (cfg_q[CFG_NO_INVERT]),
    .pos         (pos_x)
  );

  tiamc1_axis_slew #(.DEADZONE(DEADZONE), .MAX_STEP(MAX_STEP), .CENTRE(CENTRE)) u_axis_y (
    .clk_sys     (clk_sys),
    .reset_sig   (reset_sig),
    .conv_en     (conv_en_c),
    .slew_en     (slew_en_c),
    .pub_en      (pub_en_c),
    .analog      (ana_q[15:8]),
    .dig_pos     (joy_q[JOY_DOWN]),
    .dig_neg     (joy_q[JOY_UP]),
    .paddle_val  (CENTRE),
    .paddle_mode (cfg_q[CFG_PADDLE]),
    .no_invert   (cfg_q[CFG_NO_INVERT]),
    .pos         (pos_y)
  );

endmodule

// File: tb/tb_tiamc1_analog_in.sv
// Directed self-checking bench for tiamc1_analog_in (default build, no target averaging).
module tb_tiamc1_analog_in;

  logic        clk_sys = 1'b0;
  logic        reset_sig = 1'b1;
  logic        vblank = 1'b0;
  logic [31:0] joystick_0 = '0;
  logic [15:0] joystick_analog_0 = '0;
  logic [7:0]  paddle_0 = '0;
  logic [1:0]  cfg_analog = 2'b10;
  logic [7:0]  pos_x;
  logic [7:0]  pos_y;
  logic        pos_valid;

  int total = 0;
  int bad = 0;

  tiamc1_analog_in dut (
    .clk_sys           (clk_sys),
    .reset_sig         (reset_sig),
    .vblank            (vblank),
    .joystick_0        (joystick_0),
    .joystick_analog_0 (joystick_analog_0),
    .paddle_0          (paddle_0),
    .cfg_analog        (cfg_analog),
    .pos_x             (pos_x),
    .pos_y             (pos_y),
    .pos_valid         (pos_valid)
  );

  always #5 clk_sys = ~clk_sys;

  // Drive one vblank rise and wait (bounded) for the publish pulse.
  task automatic frame(output logic got);
    vblank = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 vblank = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk_sys); #1;
      if (pos_valid) got = 1'b1;
    end
    vblank = 1'b0;
  endtask

  task automatic do_reset();
    reset_sig = 1'b1;
    vblank = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 reset_sig = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic test_reset();
    int pulses;
    reset_sig = 1'b1;
    vblank = 1'b1;
    joystick_0 = 32'hFFFF_FFFF;
    joystick_analog_0 = 16'h7F81;
    paddle_0 = 8'h12;
    cfg_analog = 2'b11;
    repeat (3) @(posedge clk_sys); #1;
    total++; if (pos_x !== 8'h80) begin bad++; $display("FAIL reset_pos_x got=%h exp=80", pos_x); end
    total++; if (pos_y !== 8'h80) begin bad++; $display("FAIL reset_pos_y got=%h exp=80", pos_y); end
    total++; if (pos_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pos_valid); end
    reset_sig = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_sys); #1;
      if (pos_valid) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL held_vblank_at_release pulses=%0d exp=0", pulses); end
    total++; if (pos_x !== 8'h80) begin bad++; $display("FAIL held_vblank_pos_x got=%h exp=80", pos_x); end
    vblank = 1'b0;
    joystick_0 = '0;
    joystick_analog_0 = '0;
  endtask

  task automatic test_joystick_slew();
    logic got;
    logic [7:0] exp_x [9] = '{8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hE4, 8'hE4, 8'hE4};
    cfg_analog = 2'b10;
    joystick_analog_0 = 16'h0064;
    for (int f = 0; f < 9; f++) begin
      frame(got);
      total++; if (!got) begin bad++; $display("FAIL slew_pulse frame=%0d no pos_valid", f + 1); end
      total++; if (pos_x !== exp_x[f]) begin bad++; $display("FAIL slew_pos_x frame=%0d got=%h exp=%h", f + 1, pos_x, exp_x[f]); end
      total++; if (pos_y !== 8'h80) begin bad++; $display("FAIL slew_pos_y frame=%0d got=%h exp=80", f + 1, pos_y); end
    end
  endtask

  task automatic test_paddle();
    logic got;
    paddle_0 = 8'h37;
    cfg_analog = 2'b11;
    frame(got);
    total++; if (!got) begin bad++; $display("FAIL paddle_pulse no pos_valid"); end
    total++; if (pos_x !== 8'h37) begin bad++; $display("FAIL paddle_pos_x got=%h exp=37", pos_x); end
    total++; if (pos_y !== 8'h80) begin bad++; $display("FAIL paddle_pos_y got=%h exp=80", pos_y); end
    cfg_analog = 2'b01;
    frame(got);
    total++; if (pos_x !== 8'hC8) begin bad++; $display("FAIL paddle_inv_pos_x got=%h exp=c8", pos_x); end
    total++; if (pos_y !== 8'h7F) begin bad++; $display("FAIL paddle_inv_pos_y got=%h exp=7f", pos_y); end
  endtask

  task automatic test_digital();
    logic got;
    logic [7:0] exp_x [4] = '{8'h90, 8'hA0, 8'h90, 8'h80};
    do_reset();
    cfg_analog = 2'b10;
    joystick_analog_0 = 16'h0005;
    for (int f = 0; f < 4; f++) begin
      joystick_0 = (f < 2) ? 32'h0000_0001 : 32'h0000_0003;
      frame(got);
      total++; if (pos_x !== exp_x[f]) begin bad++; $display("FAIL digital_pos_x frame=%0d got=%h exp=%h", f + 1, pos_x, exp_x[f]); end
    end
    total++; if (pos_y !== 8'h80) begin bad++; $display("FAIL digital_pos_y got=%h exp=80", pos_y); end
    joystick_0 = '0;
  endtask

  task automatic test_deadzone();
    logic got;
    do_reset();
    cfg_analog = 2'b10;
    joystick_analog_0 = 16'h8008;
    frame(got);
    total++; if (pos_x !== 8'h88) begin bad++; $display("FAIL deadzone_edge_pos_x got=%h exp=88", pos_x); end
    total++; if (pos_y !== 8'h70) begin bad++; $display("FAIL minus128_pos_y got=%h exp=70", pos_y); end
    joystick_analog_0 = 16'h00F9;
    frame(got);
    total++; if (pos_x !== 8'h80) begin bad++; $display("FAIL inside_deadzone_pos_x got=%h exp=80", pos_x); end
    total++; if (pos_y !== 8'h80) begin bad++; $display("FAIL y_back_to_centre got=%h exp=80", pos_y); end
  endtask

  task automatic test_single_pulse();
    int first;
    int pulses;
    vblank = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 vblank = 1'b1;
    first = -1;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk_sys); #1;
      if (pos_valid) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    total++; if (first != 5) begin bad++; $display("FAIL pulse_latency edge=%0d exp=5", first); end
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_sys); #1;
      if (pos_valid) pulses++;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL held_vblank_pulses got=%0d exp=1", pulses); end
    vblank = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic got;
    do_reset();
    cfg_analog = 2'b10;
    joystick_analog_0 = 16'h0064;
    vblank = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 vblank = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(posedge clk_sys); #1;
      if (pos_valid) pulses++;
    end
    reset_sig = 1'b1;
    repeat (2) begin
      @(posedge clk_sys); #1;
      if (pos_valid) pulses++;
    end
    reset_sig = 1'b0;
    vblank = 1'b0;
    repeat (6) begin
      @(posedge clk_sys); #1;
      if (pos_valid) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL reset_mid_pulses got=%0d exp=0", pulses); end
    total++; if (pos_x !== 8'h80) begin bad++; $display("FAIL reset_mid_pos_x got=%h exp=80", pos_x); end
    frame(got);
    total++; if (!got) begin bad++; $display("FAIL after_reset_pulse no pos_valid"); end
    total++; if (pos_x !== 8'h90) begin bad++; $display("FAIL after_reset_pos_x got=%h exp=90", pos_x); end
  endtask

  initial begin
    test_reset();
    test_joystick_slew();
    test_paddle();
    test_digital();
    test_deadzone();
    test_single_pulse();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
